// File: rtl/bus_timer_periph.sv
// 65C02 bus responder: register file, 16-bit down-counting interval timer driving IRQ,
// and programmable read wait states via RDY. Define TIMER_PRESCALE_EN to add the prescaler.
module bus_timer_periph #(
    parameter logic [15:0] BASE     = 16'hFE00,
    parameter logic [1:0]  WAIT_RST = 2'd2
) (
    input  logic        clk,
    input  logic        RST,
    input  logic [15:0] AD,
    input  logic [7:0]  DO,
    input  logic        WE,
    output logic [7:0]  DI,
    output logic        SEL,
    output logic        RDY,
    output logic        IRQ
);

    typedef enum logic {IDLE, STALL} state_t;

    state_t      state, state_nx;
    logic [1:0]  rem, rem_nx;
    logic [1:0]  wait_r;
    logic        en, ie, oneshot, exp_r;
    logic [15:0] reload, count;
    logic [7:0]  shadow;
    logic [7:0]  rdata;
    logic        tick, expire;

    // RDY comes straight from the state register so reset releases the CPU at once
    assign RDY = (state == IDLE);

    logic acc, rd_acc, wr_acc;
    assign acc    = RDY && (AD[15:3] == BASE[15:3]);
    assign rd_acc = acc && !WE;
    assign wr_acc = acc && WE;

    logic wr_ctrl, wr_stat, wr_rl, wr_rh, wr_wait, rd_cl;
    assign wr_ctrl = wr_acc && (AD[2:0] == 3'd0);
    assign wr_stat = wr_acc && (AD[2:0] == 3'd1);
    assign wr_rl   = wr_acc && (AD[2:0] == 3'd2);
    assign wr_rh   = wr_acc && (AD[2:0] == 3'd3);
    assign wr_wait = wr_acc && (AD[2:0] == 3'd7);
    assign rd_cl   = rd_acc && (AD[2:0] == 3'd4);

`ifdef TIMER_PRESCALE_EN
    logic [7:0] prescale_r, presc;
    logic       wr_psc;
    assign wr_psc = wr_acc && (AD[2:0] == 3'd6);
    assign tick   = (presc == prescale_r);

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            prescale_r <= 8'd0;
            presc      <= 8'd0;
        end else begin
            if (wr_psc)
                prescale_r <= DO;
            if (wr_psc || wr_rh)
                presc <= 8'd0;
            else if (en)
                presc <= tick ? 8'd0 : presc + 8'd1;
        end
    end
`else
    assign tick = 1'b1;
`endif

    // A RELOAD_H write swallows any tick in the same cycle
    assign expire = en && tick && (count == 16'd0) && !wr_rh;

    always_comb begin
        state_nx = state;
        rem_nx   = rem;
        case (state)
            IDLE: begin
                if (rd_acc && (wait_r != 2'd0)) begin
                    state_nx = STALL;
                    rem_nx   = wait_r;
                end
            end
            STALL: begin
                if (rem == 2'd1)
                    state_nx = IDLE;
                else
                    rem_nx = rem - 2'd1;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            rem   <= 2'd0;
        end else begin
            state <= state_nx;
            rem   <= rem_nx;
        end
    end

    always_comb begin
        rdata = 8'd0;
        case (AD[2:0])
            3'd0: rdata = {5'd0, oneshot, ie, en};
            3'd1: rdata = {7'd0, exp_r};
            3'd2: rdata = reload[7:0];
            3'd3: rdata = reload[15:8];
            3'd4: rdata = count[7:0];
            3'd5: rdata = shadow;
`ifdef TIMER_PRESCALE_EN
            3'd6: rdata = prescale_r;
`endif
            3'd7: rdata = {6'd0, wait_r};
            default: rdata = 8'd0;
        endcase
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            DI      <= 8'd0;
            SEL     <= 1'b0;
            IRQ     <= 1'b0;
            en      <= 1'b0;
            ie      <= 1'b0;
            oneshot <= 1'b0;
            exp_r   <= 1'b0;
            reload  <= 16'hFFFF;
            count   <= 16'hFFFF;
            shadow  <= 8'd0;
            wait_r  <= WAIT_RST;
        end else begin
            // DI/SEL freeze while the CPU is held off
            if (RDY) begin
                DI  <= rd_acc ? rdata : 8'd0;
                SEL <= rd_acc;
            end
            if (wr_ctrl) begin
                en      <= DO[0];
                ie      <= DO[1];
                oneshot <= DO[2];
            end else if (expire && oneshot) begin
                en <= 1'b0;
            end
            exp_r <= expire | (exp_r & ~(wr_stat & DO[0]));
            if (wr_rl)
                reload[7:0] <= DO;
            if (wr_rh) begin
                reload[15:8] <= DO;
                count        <= {DO, reload[7:0]};
            end else if (en && tick) begin
                count <= (count == 16'd0) ? reload : count - 16'd1;
            end
            if (rd_cl)
                shadow <= count[15:8];
            if (wr_wait)
                wait_r <= DO[1:0];
            IRQ <= exp_r & ie;
        end
    end

endmodule

// File: tb/tb_bus_timer_periph.sv
// Directed bench for bus_timer_periph: reset, timer modes, wait states, shadow read, races.
module tb_bus_timer_periph;

    localparam logic [15:0] BASE = 16'hFE00;

    logic        clk, RST, WE, SEL, RDY, IRQ;
    logic [15:0] AD;
    logic [7:0]  DO, DI, d;
    int          errors = 0;
    int          checks = 0;

    bus_timer_periph #(.BASE(BASE), .WAIT_RST(2'd2)) dut (
        .clk(clk), .RST(RST), .AD(AD), .DO(DO), .WE(WE),
        .DI(DI), .SEL(SEL), .RDY(RDY), .IRQ(IRQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wr(input logic [2:0] off, input logic [7:0] data);
        @(negedge clk); AD = BASE + {13'd0, off}; WE = 1'b1; DO = data;
        @(posedge clk); #1; AD = 16'h0000; WE = 1'b0; DO = 8'h00;
    endtask

    task automatic rd(input logic [2:0] off, output logic [7:0] data);
        @(negedge clk); AD = BASE + {13'd0, off}; WE = 1'b0;
        @(posedge clk); #1; data = DI; AD = 16'h0000;
        for (int i = 0; i < 8 && !RDY; i++) begin @(posedge clk); #1; end
        checks++; if (RDY !== 1'b1) begin errors++; $display("FAIL rd_rdy_timeout got=%b exp=1", RDY); end
    endtask

    task automatic test_reset;
        RST = 1'b1; AD = 16'h0000; WE = 1'b0; DO = 8'h00;
        repeat (2) @(posedge clk); #1;
        checks++; if (RDY !== 1'b1) begin errors++; $display("FAIL rst_rdy got=%b exp=1", RDY); end
        checks++; if (DI !== 8'h00) begin errors++; $display("FAIL rst_di got=%h exp=00", DI); end
        checks++; if (SEL !== 1'b0) begin errors++; $display("FAIL rst_sel got=%b exp=0", SEL); end
        checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL rst_irq got=%b exp=0", IRQ); end
        @(negedge clk); RST = 1'b0;
        rd(3'd7, d);
        checks++; if (d !== 8'h02) begin errors++; $display("FAIL rst_wait got=%h exp=02", d); end
        rd(3'd4, d);
        checks++; if (d !== 8'hFF) begin errors++; $display("FAIL rst_count_l got=%h exp=ff", d); end
    endtask

    task automatic test_reset_mid_stall;
        wr(3'd2, 8'h00); wr(3'd3, 8'h00); wr(3'd0, 8'h03); wr(3'd0, 8'h02); wr(3'd7, 8'h03);
        @(negedge clk); AD = BASE; WE = 1'b0;
        @(posedge clk); #1; AD = 16'h0000;
        checks++; if (RDY !== 1'b0) begin errors++; $display("FAIL ms_rdy_low got=%b exp=0", RDY); end
        checks++; if (DI !== 8'h02) begin errors++; $display("FAIL ms_ctrl got=%h exp=02", DI); end
        checks++; if (IRQ !== 1'b1) begin errors++; $display("FAIL ms_irq_pre got=%b exp=1", IRQ); end
        @(posedge clk); #1; RST = 1'b1; #1;
        checks++; if (RDY !== 1'b1) begin errors++; $display("FAIL ms_rdy got=%b exp=1", RDY); end
        checks++; if (DI !== 8'h00) begin errors++; $display("FAIL ms_di got=%h exp=00", DI); end
        checks++; if (SEL !== 1'b0) begin errors++; $display("FAIL ms_sel got=%b exp=0", SEL); end
        checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL ms_irq got=%b exp=0", IRQ); end
        @(negedge clk); RST = 1'b0;
        rd(3'd5, d); checks++; if (d !== 8'h00) begin errors++; $display("FAIL ms_shadow got=%h exp=00", d); end
        rd(3'd0, d); checks++; if (d !== 8'h00) begin errors++; $display("FAIL ms_ctrl_rst got=%h exp=00", d); end
        rd(3'd1, d); checks++; if (d !== 8'h00) begin errors++; $display("FAIL ms_stat got=%h exp=00", d); end
        rd(3'd2, d); checks++; if (d !== 8'hFF) begin errors++; $display("FAIL ms_rl got=%h exp=ff", d); end
        rd(3'd3, d); checks++; if (d !== 8'hFF) begin errors++; $display("FAIL ms_rh got=%h exp=ff", d); end
        rd(3'd4, d); checks++; if (d !== 8'hFF) begin errors++; $display("FAIL ms_cl got=%h exp=ff", d); end
        rd(3'd6, d); checks++; if (d !== 8'h00) begin errors++; $display("FAIL ms_psc got=%h exp=00", d); end
        rd(3'd7, d); checks++; if (d !== 8'h02) begin errors++; $display("FAIL ms_wait got=%h exp=02", d); end
    endtask

    task automatic test_periodic;
        wr(3'd7, 8'h00);
        wr(3'd2, 8'h04); wr(3'd3, 8'h00); wr(3'd0, 8'h03);
        repeat (5) begin @(posedge clk); #1; end
        checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL per_irq_early got=%b exp=0", IRQ); end
        rd(3'd4, d);
        checks++; if (d !== 8'h04) begin errors++; $display("FAIL per_reload got=%h exp=04", d); end
        checks++; if (IRQ !== 1'b1) begin errors++; $display("FAIL per_irq_rise got=%b exp=1", IRQ); end
        wr(3'd1, 8'h01);
        checks++; if (IRQ !== 1'b1) begin errors++; $display("FAIL per_irq_hold got=%b exp=1", IRQ); end
        @(posedge clk); #1;
        checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL per_irq_drop got=%b exp=0", IRQ); end
        wr(3'd0, 8'h00); wr(3'd1, 8'h01);
    endtask

    task automatic test_oneshot;
        wr(3'd2, 8'h04); wr(3'd3, 8'h00); wr(3'd0, 8'h07);
        repeat (8) begin @(posedge clk); #1; end
        rd(3'd0, d); checks++; if (d !== 8'h06) begin errors++; $display("FAIL os_ctrl got=%h exp=06", d); end
        rd(3'd4, d); checks++; if (d !== 8'h04) begin errors++; $display("FAIL os_count got=%h exp=04", d); end
        rd(3'd1, d); checks++; if (d !== 8'h01) begin errors++; $display("FAIL os_exp got=%h exp=01", d); end
        wr(3'd1, 8'h01);
        repeat (10) begin @(posedge clk); #1; end
        rd(3'd1, d); checks++; if (d !== 8'h00) begin errors++; $display("FAIL os_once got=%h exp=00", d); end
        rd(3'd4, d); checks++; if (d !== 8'h04) begin errors++; $display("FAIL os_hold got=%h exp=04", d); end
        wr(3'd0, 8'h00);
    endtask

    task automatic test_wait_states;
        wr(3'd7, 8'h02);
        @(negedge clk); AD = BASE + 16'd7; WE = 1'b0;
        @(posedge clk); #1; AD = BASE + 16'd2; WE = 1'b1; DO = 8'hAA;
        for (int i = 0; i < 2; i++) begin
            checks++; if (RDY !== 1'b0) begin errors++; $display("FAIL ws_rdy_low[%0d] got=%b exp=0", i, RDY); end
            checks++; if (DI !== 8'h02 || SEL !== 1'b1) begin errors++; $display("FAIL ws_hold[%0d] got=%h/%b exp=02/1", i, DI, SEL); end
            @(posedge clk); #1;
        end
        AD = 16'h0000; WE = 1'b0; DO = 8'h00;
        checks++; if (RDY !== 1'b1) begin errors++; $display("FAIL ws_rdy_back got=%b exp=1", RDY); end
        checks++; if (DI !== 8'h02 || SEL !== 1'b1) begin errors++; $display("FAIL ws_hold_end got=%h/%b exp=02/1", DI, SEL); end
        @(posedge clk); #1;
        checks++; if (DI !== 8'h00 || SEL !== 1'b0) begin errors++; $display("FAIL ws_idle got=%h/%b exp=00/0", DI, SEL); end
        wr(3'd7, 8'h00);
        rd(3'd2, d); checks++; if (d !== 8'h04) begin errors++; $display("FAIL ws_no_decode got=%h exp=04", d); end
    endtask

    task automatic test_count_shadow;
        wr(3'd2, 8'h00); wr(3'd0, 8'h01); wr(3'd3, 8'h01);
        rd(3'd4, d); checks++; if (d !== 8'h00) begin errors++; $display("FAIL sh_cl got=%h exp=00", d); end
        rd(3'd5, d); checks++; if (d !== 8'h01) begin errors++; $display("FAIL sh_ch got=%h exp=01", d); end
        rd(3'd4, d); checks++; if (d !== 8'hFE) begin errors++; $display("FAIL sh_cl2 got=%h exp=fe", d); end
        rd(3'd5, d); checks++; if (d !== 8'h00) begin errors++; $display("FAIL sh_ch2 got=%h exp=00", d); end
        wr(3'd0, 8'h00);
    endtask

    task automatic test_exp_clear_race;
        wr(3'd2, 8'h00); wr(3'd3, 8'h00); wr(3'd0, 8'h01); wr(3'd1, 8'h01);
        rd(3'd1, d); checks++; if (d !== 8'h01) begin errors++; $display("FAIL race_set_wins got=%h exp=01", d); end
        wr(3'd0, 8'h00); wr(3'd1, 8'h01);
        rd(3'd1, d); checks++; if (d !== 8'h00) begin errors++; $display("FAIL race_cleared got=%h exp=00", d); end
    endtask

    task automatic test_prescale;
`ifdef TIMER_PRESCALE_EN
        wr(3'd6, 8'h03); wr(3'd2, 8'h01); wr(3'd3, 8'h00); wr(3'd0, 8'h03);
        repeat (8) begin @(posedge clk); #1; end
        checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL psc_irq_early got=%b exp=0", IRQ); end
        @(posedge clk); #1;
        checks++; if (IRQ !== 1'b1) begin errors++; $display("FAIL psc_irq1 got=%b exp=1", IRQ); end
        wr(3'd1, 8'h01);
        repeat (6) begin @(posedge clk); #1; end
        checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL psc_irq_gap got=%b exp=0", IRQ); end
        @(posedge clk); #1;
        checks++; if (IRQ !== 1'b1) begin errors++; $display("FAIL psc_irq2 got=%b exp=1", IRQ); end
        wr(3'd0, 8'h00);
`else
        wr(3'd6, 8'hFF);
        rd(3'd6, d); checks++; if (d !== 8'h00) begin errors++; $display("FAIL psc_absent got=%h exp=00", d); end
`endif
    endtask

    initial begin
        test_reset;
        test_reset_mid_stall;
        test_periodic;
        test_oneshot;
        test_wait_states;
        test_count_shadow;
        test_exp_clear_race;
        test_prescale;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
